// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: packet-level round-robin arbiter sharing one NoC router
// local sender port among NUM_REQ requesters. A grant is taken on a header
// flit and held until that requester's tail is accepted, so wormhole packets
// never interleave. Flits reach the router through one registered stage.

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `Noc_Data_Width,
  parameter int GW         = $clog2(NUM_REQ)
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_is_header,
  input  logic [NUM_REQ-1:0]            req_is_tail,
  output logic                          snd_valid,
  input  logic                          snd_ready,
  output logic [DATA_WIDTH-1:0]         snd_flit,
  output logic                          snd_is_header,
  output logic                          snd_is_tail,
  input  logic                          snd_vc_ready,
  output logic                          busy,
  output logic [GW-1:0]                 cur_grant
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state;
  logic [GW-1:0]         rr_ptr;

  logic [NUM_REQ-1:0]    cand;
  logic                  found;
  logic [GW-1:0]         sel;
  logic [31:0]           idx;
  logic [GW-1:0]         idx_g;

  logic [DATA_WIDTH-1:0] flit_arr [NUM_REQ];
  logic                  can_load;
  logic                  accept;

  // Split the packed requester flit bus into one word per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign flit_arr[i] = req_flit[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cand     = req_valid & req_is_header;
  assign can_load = ~snd_valid | snd_ready;
  assign accept   = (state == LOCKED) & req_valid[cur_grant] & can_load;
  assign busy     = (state == LOCKED);

  // Rotating-priority search: first header candidate after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    idx_g = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(rr_ptr) + 32'd1 + 32'(k)) % 32'(NUM_REQ);
      idx_g = GW'(idx);
      if (!found && cand[idx_g]) begin
        found = 1'b1;
        sel   = idx_g;
      end
    end
  end

  // Only the granted requester sees ready, and only while the output stage can take a flit.
  always_comb begin
    req_ready = '0;
    if (state == LOCKED) begin
      req_ready[cur_grant] = can_load;
    end
  end

  // Arbitration FSM plus the single registered output stage.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state         <= IDLE;
      rr_ptr        <= GW'(NUM_REQ - 1);
      cur_grant     <= '0;
      snd_valid     <= 1'b0;
      snd_flit      <= '0;
      snd_is_header <= 1'b0;
      snd_is_tail   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snd_vc_ready && found) begin
            cur_grant <= sel;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && req_is_tail[cur_grant]) begin
            state  <= IDLE;
            rr_ptr <= cur_grant;
          end
        end
        default: state <= IDLE;
      endcase

      // A load in the same cycle as a drain keeps the stage full at one flit per cycle.
      if (accept) begin
        snd_valid     <= 1'b1;
        snd_flit      <= flit_arr[cur_grant];
        snd_is_header <= req_is_header[cur_grant];
        snd_is_tail   <= req_is_tail[cur_grant];
      end else if (snd_valid && snd_ready) begin
        snd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: packet-level round-robin
// reference model feeding a flit scoreboard, plus directed timing checks.

module tb_noc_inject_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int GW = 2;

  logic            noc_clk = 1'b0;
  logic            noc_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_flit;
  logic [N-1:0]    req_is_header;
  logic [N-1:0]    req_is_tail;
  logic            snd_valid;
  logic            snd_ready;
  logic [DW-1:0]   snd_flit;
  logic            snd_is_header;
  logic            snd_is_tail;
  logic            snd_vc_ready;
  logic            busy;
  logic [GW-1:0]   cur_grant;

  noc_inject_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .GW        (GW)
  ) dut (
    .noc_clk      (noc_clk),
    .noc_rst      (noc_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_flit     (req_flit),
    .req_is_header(req_is_header),
    .req_is_tail  (req_is_tail),
    .snd_valid    (snd_valid),
    .snd_ready    (snd_ready),
    .snd_flit     (snd_flit),
    .snd_is_header(snd_is_header),
    .snd_is_tail  (snd_is_tail),
    .snd_vc_ready (snd_vc_ready),
    .busy         (busy),
    .cur_grant    (cur_grant)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct packed {
    logic [DW-1:0] flit;
    logic          hdr;
    logic          tail;
  } ent_t;

  ent_t pq    [N][$];   // flits each requester still has to send
  ent_t stg   [N][$];   // packets staged for the next batch
  ent_t exp_q [$];      // expected flit order on the sender port

  int checks = 0;
  int errors = 0;
  int last_srv = N - 1;
  int cyc = 0;
  int hs_prev = 0;
  int hs_last = 0;
  int glog [$];

  bit sr_rand = 0, vc_rand = 0, bub_en = 0;
  bit sr_force0 = 0, vc_force0 = 0, stray_en = 0;

  always @(posedge noc_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_pkt(input int r, input int len, input logic [DW-1:0] base, input bit rnd);
    ent_t e;
    for (int k = 0; k < len; k++) begin
      e.flit = rnd ? DW'($urandom) : base + DW'(k);
      e.hdr  = (k == 0);
      e.tail = (k == len - 1);
      stg[r].push_back(e);
    end
  endtask

  // Packet-level model: every requester with packets left is always offering a
  // header, so packets leave in rotating order starting after the last served.
  task automatic commit();
    int   rem [N];
    int   ptr, total, c;
    bit   got;
    ent_t e;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      for (int k = 0; k < stg[i].size(); k++) begin
        pq[i].push_back(stg[i][k]);
        if (stg[i][k].tail) rem[i]++;
      end
      total += rem[i];
    end
    ptr = last_srv;
    while (total > 0) begin
      got = 0;
      c = 0;
      for (int k = 1; k <= N; k++) begin
        if (!got && rem[(ptr + k) % N] > 0) begin
          got = 1;
          c = (ptr + k) % N;
        end
      end
      do begin
        e = stg[c].pop_front();
        exp_q.push_back(e);
      end while (!e.tail);
      rem[c]--;
      total--;
      ptr = c;
    end
    last_srv = ptr;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      @(negedge noc_clk);
      #2;
      n++;
      done = (exp_q.size() == 0) && !busy && !snd_valid;
      for (int i = 0; i < N; i++) if (pq[i].size() != 0) done = 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got %0d flits pending, required 0", name, exp_q.size());
    end
  endtask

  // Requester drivers and sender-port flow control.
  initial begin
    logic [N-1:0] acc;
    req_valid = '0;
    req_flit = '0;
    req_is_header = '0;
    req_is_tail = '0;
    snd_ready = 1'b0;
    snd_vc_ready = 1'b0;
    forever begin
      @(negedge noc_clk);
      acc = req_valid & req_ready;
      @(posedge noc_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          req_flit[i*DW +: DW] = pq[i][0].flit;
          req_is_header[i] = pq[i][0].hdr;
          req_is_tail[i] = pq[i][0].tail;
          req_valid[i] = pq[i][0].hdr || !bub_en || ($urandom_range(3) != 0);
        end else if (i == 0 && stray_en) begin
          req_flit[i*DW +: DW] = 16'h5A5A;
          req_is_header[i] = 1'b0;
          req_is_tail[i] = 1'b0;
          req_valid[i] = 1'b1;
        end else begin
          req_valid[i] = 1'b0;
          req_is_header[i] = 1'b0;
          req_is_tail[i] = 1'b0;
        end
      end
      snd_ready = sr_force0 ? 1'b0 : (sr_rand ? ($urandom_range(9) < 7) : 1'b1);
      snd_vc_ready = vc_force0 ? 1'b0 : (vc_rand ? ($urandom_range(4) != 0) : 1'b1);
    end
  end

  // Scoreboard monitor: every sender-port handshake must match the next expected flit.
  initial begin
    ent_t e;
    forever begin
      @(negedge noc_clk);
      if (noc_rst === 1'b0 && snd_valid && snd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got flit 0x%0h, required no flit", snd_flit);
        end else begin
          e = exp_q.pop_front();
          if ({snd_flit, snd_is_header, snd_is_tail} !== e) begin
            errors++;
            $display("FAIL sb_flit: got flit=0x%0h hdr=%b tail=%b, required flit=0x%0h hdr=%b tail=%b",
                     snd_flit, snd_is_header, snd_is_tail, e.flit, e.hdr, e.tail);
          end
        end
        hs_prev = hs_last;
        hs_last = cyc;
      end
    end
  end

  // Grant log: record cur_grant each time a new packet grant is taken.
  initial begin
    bit bp;
    bp = 0;
    forever begin
      @(posedge noc_clk);
      #2;
      if (busy && !bp) glog.push_back(int'(cur_grant));
      bp = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, total, np;
    int exp_order [8];
    noc_rst = 1'b1;

    // Reset state
    @(posedge noc_clk);
    #2;
    chk("rst_snd_valid", 32'(snd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_cur_grant", 32'(cur_grant), 0);
    chk("rst_snd_flit", 32'(snd_flit), 0);
    chk("rst_snd_marks", 32'({snd_is_header, snd_is_tail}), 0);
    repeat (2) @(negedge noc_clk);
    #2;
    noc_rst = 1'b0;

    // Single 3-flit packet from requester 2: latency and markers
    @(negedge noc_clk);
    #2;
    add_pkt(2, 3, 16'h00A0, 0);
    commit();
    @(posedge noc_clk); #2;
    chk("sp_c0_snd_valid", 32'(snd_valid), 0);
    chk("sp_c0_busy", 32'(busy), 0);
    @(posedge noc_clk); #2;
    chk("sp_grant", 32'(cur_grant), 2);
    chk("sp_busy", 32'(busy), 1);
    chk("sp_req_ready", 32'(req_ready), 32'h4);
    chk("sp_c1_snd_valid", 32'(snd_valid), 0);
    @(posedge noc_clk); #2;
    chk("sp_c2_snd_valid", 32'(snd_valid), 1);
    chk("sp_flit0", 32'(snd_flit), 32'hA0);
    chk("sp_marks0", 32'({snd_is_header, snd_is_tail}), 2);
    @(posedge noc_clk); #2;
    chk("sp_flit1", 32'(snd_flit), 32'hA1);
    chk("sp_marks1", 32'({snd_is_header, snd_is_tail}), 0);
    chk("sp_busy_mid", 32'(busy), 1);
    @(posedge noc_clk); #2;
    chk("sp_flit2", 32'(snd_flit), 32'hA2);
    chk("sp_marks2", 32'({snd_is_header, snd_is_tail}), 1);
    chk("sp_busy_after_tail", 32'(busy), 0);
    wait_idle(50, "single_packet");

    // Backpressure mid-packet
    @(negedge noc_clk);
    #2;
    add_pkt(1, 4, 16'h00B0, 0);
    commit();
    n = 0;
    while (!(snd_valid && snd_flit == 16'h00B1) && n < 30) begin
      @(posedge noc_clk); #2;
      n++;
    end
    chk("bp_reach_b1", 32'(snd_flit), 32'hB1);
    sr_force0 = 1;
    repeat (5) begin
      @(posedge noc_clk); #2;
      chk("bp_hold_flit", 32'(snd_flit), 32'hB2);
      chk("bp_hold_valid", 32'(snd_valid), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    sr_force0 = 0;
    wait_idle(50, "backpressure");

    // VC gating with a stray non-header flit on requester 0
    @(negedge noc_clk);
    #2;
    vc_force0 = 1;
    stray_en = 1;
    repeat (2) @(negedge noc_clk);
    #2;
    add_pkt(3, 2, 16'h00C0, 0);
    commit();
    repeat (4) begin
      @(posedge noc_clk); #2;
      chk("vc_gate_busy", 32'(busy), 0);
      chk("vc_gate_ready", 32'(req_ready), 0);
    end
    vc_force0 = 0;
    @(posedge noc_clk); #2;
    chk("vc_release_busy0", 32'(busy), 0);
    @(posedge noc_clk); #2;
    chk("vc_release_busy1", 32'(busy), 1);
    chk("vc_release_grant", 32'(cur_grant), 3);
    repeat (10) begin
      @(posedge noc_clk); #2;
      chk("stray_ready", 32'(req_ready[0]), 0);
    end
    chk("stray_no_grant", 32'(busy), 0);
    stray_en = 0;
    wait_idle(50, "vc_stray");

    // Single-flit packets from requesters 1 and 3
    @(negedge noc_clk);
    #2;
    add_pkt(1, 1, 16'h00D1, 0);
    add_pkt(3, 1, 16'h00D3, 0);
    commit();
    wait_idle(50, "single_flit");
    chk("sf_gap", 32'(hs_last - hs_prev), 2);

    // Reset in the middle of a 4-flit packet
    @(negedge noc_clk);
    #2;
    add_pkt(2, 4, 16'h00E0, 0);
    commit();
    n = 0;
    while (!(snd_valid && snd_flit == 16'h00E1) && n < 30) begin
      @(posedge noc_clk); #2;
      n++;
    end
    chk("rst_mid_reach", 32'(snd_flit), 32'hE1);
    #1;
    noc_rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    last_srv = N - 1;
    #1;
    chk("rst_mid_snd_valid", 32'(snd_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_req_ready", 32'(req_ready), 0);
    @(negedge noc_clk);
    #2;
    noc_rst = 1'b0;
    add_pkt(3, 2, 16'h00F3, 0);
    add_pkt(1, 2, 16'h00F1, 0);
    commit();
    n = 0;
    while (!busy && n < 20) begin
      @(posedge noc_clk); #2;
      n++;
    end
    chk("rst_first_grant", 32'(cur_grant), 1);
    wait_idle(50, "post_reset");

    // Round-robin fairness: all requesters continuously offer 2-flit packets
    @(negedge noc_clk);
    #2;
    glog.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) add_pkt(i, 2, DW'(16'h0100 * (i + 1) + 16'h10 * p), 0);
    commit();
    wait_idle(100, "fairness");
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("rr_count", 32'(glog.size()), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < glog.size()) chk("rr_order", 32'(glog[k]), 32'(exp_order[k]));
    end

    // Randomized batches with random flow control and mid-packet bubbles
    sr_rand = 1;
    vc_rand = 1;
    bub_en = 1;
    for (int b = 0; b < 40; b++) begin
      @(negedge noc_clk);
      #2;
      total = 0;
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(2);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 4), '0, 1);
        total += np;
      end
      if (total == 0) add_pkt($urandom_range(N - 1), $urandom_range(1, 4), '0, 1);
      commit();
      wait_idle(800, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
